// File: rtl/data_memory_sized.sv
// data_memory_sized
//   Multi-cycle data memory for the MEM stage. It supports byte, halfword and
//   word loads and stores (lb/lbu/lh/lhu/sb/sh/sw) with sign or zero extension.
//   It has a fixed access latency, and a Busy/Ready handshake drives the stall
//   logic.
//
//   Parameters:
//     DEPTH      number of 32-bit words (power of two)
//     ADDR_BITS  log2(DEPTH); the word index is Address[ADDR_BITS+1:2]
//     LATENCY    edges from request acceptance to access completion (>=1)
//
//   Ports:
//     Clk          rising-edge clock
//     Reset        synchronous, active-high reset
//     Address      byte address; upper bits are ignored, so it wraps modulo DEPTH*4
//     WriteData    store data; low byte/halfword is used for sub-word stores
//     MemWrite     write request (wins when MemRead is also high)
//     MemRead      read request
//     Size         00 byte, 01 halfword, 10/11 word
//     Unsigned     1 = zero-extend loads, 0 = sign-extend
//     ReadData     extended load result, held until the next read completes
//     Busy         high while a request is in flight
//     Ready        one-cycle completion pulse
//     MisalignErr  misaligned-access flag, valid with Ready
//
//   Optional feature macro: DMEM_MISALIGN_TRAP_EN
//     Defined:   misaligned halfword/word accesses are trapped. They make no
//                memory update, leave ReadData unchanged, and raise MisalignErr
//                together with Ready.
//     Undefined: the low address bits are ignored for halfword and word
//                accesses, and MisalignErr stays 0.
`timescale 1ns/1ps

module data_memory_sized #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Ready,
  output logic        MisalignErr
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                accept, perform;

  logic [ADDR_BITS+1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic                 wr_q;

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 is_byte, is_half, is_word;
  logic                 mis;
  logic [3:0]           be;
  logic [31:0]          wdata_lane;
  logic [31:0]          old_word;
  logic [31:0]          load_val;
  logic                 err_q;

  logic [31:0] mem [DEPTH];

  // Upper address bits only take part in the modulo wrap.
  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_BITS+2];

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic zero_ext);
    return zero_ext ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic zero_ext);
    return zero_ext ? {16'b0, h} : {{16{h[15]}}, h};
  endfunction

  // Control state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    perform   = 1'b0;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          perform   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at acceptance; inputs are not looked at again until IDLE
  always_ff @(posedge Clk) begin
    if (accept) begin
      addr_q  <= Address[ADDR_BITS+1:0];
      wdata_q <= WriteData;
      size_q  <= Size;
      uns_q   <= Unsigned;
      wr_q    <= MemWrite;
    end
  end

  // Lane decode, byte enables and load extraction from the captured request
  always_comb begin
    word_idx = addr_q[ADDR_BITS+1:2];
    is_byte  = (size_q == 2'b00);
    is_half  = (size_q == 2'b01);
    is_word  = size_q[1];

    // The lane is always forced to the natural alignment. When trapping is
    // enabled, misaligned accesses never use the lane, so one path serves both builds.
    if (is_word)      lane = 2'b00;
    else if (is_half) lane = {addr_q[1], 1'b0};
    else              lane = addr_q[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif

    if (is_byte) begin
      be         = 4'b0001 << lane;
      wdata_lane = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be         = 4'b0011 << lane;
      wdata_lane = {2{wdata_q[15:0]}};
    end else begin
      be         = 4'b1111;
      wdata_lane = wdata_q;
    end

    old_word = mem[word_idx];
    if (is_byte)      load_val = extend_byte(old_word[{lane, 3'b000} +: 8], uns_q);
    else if (is_half) load_val = extend_half(lane[1] ? old_word[31:16] : old_word[15:0], uns_q);
    else              load_val = old_word;
  end

  // Sub-word stores merge into the existing word through byte enables
  always_ff @(posedge Clk) begin
    if (!Reset && perform && wr_q && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  // Completion results: load data and error flag, presented in DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ReadData <= '0;
      err_q    <= 1'b0;
    end else if (perform) begin
      err_q <= mis;
      if (!wr_q && !mis) ReadData <= load_val;
    end
  end

  assign Busy        = (state == WAIT);
  assign Ready       = (state == DONE);
  assign MisalignErr = (state == DONE) && err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
`timescale 1ns/1ps

module tb_data_memory_sized;

  localparam int LAT = 2;
  localparam int DEP = 1024;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  Size = '0;
  logic        Unsigned = 1'b0;
  logic [31:0] ReadData;
  logic        Busy, Ready, MisalignErr;

  data_memory_sized #(.DEPTH(DEP), .ADDR_BITS(10), .LATENCY(LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .Busy(Busy), .Ready(Ready), .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte-addressed memory plus the architectural load result
  logic [7:0]  bm [DEP*4];
  logic [31:0] model_rd = '0;
  logic        model_mis = 1'b0;

  task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [1:0] sz, input logic un);
    int unsigned a, n;
    logic [31:0] v;
    a = addr % (DEP * 4);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) begin
      model_mis = 1'b1;
      return;
    end
`endif
    model_mis = 1'b0;
    a = a - (a % n);
    if (wr) begin
      for (int i = 0; i < n; i++) bm[a+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(bm[a+i]) << (8*i));
      if (n < 4 && !un && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      model_rd = v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete access; returns result, latency in edges after acceptance,
  // error flag, and whether Busy was high in WAIT and low at completion.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic un,
                           output logic [31:0] rdata, output int lat,
                           output logic mis, output logic busy_ok);
    logic b1;
    @(negedge Clk);
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd; Size = sz; Unsigned = un;
    @(posedge Clk);
    @(negedge Clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    lat = 1;
    b1 = Busy;
    while (!Ready && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    rdata = ReadData;
    mis = MisalignErr;
    busy_ok = (LAT >= 1) ? (b1 && !Busy) : 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] exp;   // ReadData after completion
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        mis, bok;
    int          pulses;

    // Reset over two edges
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk("reset_readdata", ReadData, 32'h0);
    chk("reset_busy", {31'b0, Busy}, 32'h0);
    chk("reset_ready", {31'b0, Ready}, 32'h0);
    chk("reset_misalign", {31'b0, MisalignErr}, 32'h0);

    //              rd   wr   addr           wdata          sz     un   expected ReadData
    tbl.push_back('{1'b0,1'b1,32'h0000_0010,32'hDEAD_BEEF,2'd2,1'b0,32'h0000_0000});
    tbl.push_back('{1'b1,1'b0,32'h0000_0010,32'h0,        2'd2,1'b0,32'hDEAD_BEEF});
    tbl.push_back('{1'b0,1'b1,32'h0000_0020,32'h1122_3344,2'd2,1'b0,32'hDEAD_BEEF});
    tbl.push_back('{1'b0,1'b1,32'h0000_0021,32'h1234_56AA,2'd0,1'b0,32'hDEAD_BEEF});
    tbl.push_back('{1'b1,1'b0,32'h0000_0020,32'h0,        2'd2,1'b0,32'h1122_AA44});
    tbl.push_back('{1'b1,1'b0,32'h0000_0021,32'h0,        2'd0,1'b0,32'hFFFF_FFAA});
    tbl.push_back('{1'b1,1'b0,32'h0000_0021,32'h0,        2'd0,1'b1,32'h0000_00AA});
    tbl.push_back('{1'b1,1'b0,32'h0000_0022,32'h0,        2'd1,1'b0,32'h0000_1122});
    tbl.push_back('{1'b0,1'b1,32'h0000_0030,32'h0000_CAFE,2'd2,1'b0,32'h0000_1122});
    tbl.push_back('{1'b0,1'b1,32'h0000_0032,32'hABCD_8001,2'd1,1'b0,32'h0000_1122});
    tbl.push_back('{1'b1,1'b0,32'h0000_0032,32'h0,        2'd1,1'b0,32'hFFFF_8001});
    tbl.push_back('{1'b1,1'b0,32'h0000_0032,32'h0,        2'd1,1'b1,32'h0000_8001});
    tbl.push_back('{1'b1,1'b0,32'h0000_0030,32'h0,        2'd2,1'b0,32'h8001_CAFE});
    tbl.push_back('{1'b0,1'b1,32'h0000_0040,32'h1234_5678,2'd2,1'b0,32'h8001_CAFE});
    tbl.push_back('{1'b0,1'b1,32'h0000_0054,32'h0101_0101,2'd2,1'b0,32'h8001_CAFE});
    tbl.push_back('{1'b0,1'b1,32'h0000_1000,32'h0A0B_0C0D,2'd2,1'b0,32'h8001_CAFE});
    tbl.push_back('{1'b1,1'b0,32'h0000_0000,32'h0,        2'd2,1'b0,32'h0A0B_0C0D});
    tbl.push_back('{1'b1,1'b0,32'h0000_0010,32'h0,        2'd3,1'b1,32'hDEAD_BEEF});

    foreach (tbl[i]) begin
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].sz, tbl[i].un,
                rd, lat, mis, bok);
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].sz, tbl[i].un);
      chk($sformatf("vec%0d_readdata", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT + 1));
      chk($sformatf("vec%0d_misalign", i), {31'b0, mis}, 32'h0);
      chk($sformatf("vec%0d_busy", i), {31'b0, bok}, 32'h1);
    end

    // Requests held through WAIT and DONE are ignored
    @(negedge Clk);
    MemWrite = 1'b1; Address = 32'h50; WriteData = 32'h600D_F00D; Size = 2'd2; Unsigned = 1'b0;
    @(posedge Clk);
    pulses = 0;
    for (int n = 1; n <= LAT + 6; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        Address = 32'h54; WriteData = 32'hBAD0_BAD0; MemRead = 1'b1;
      end
      if (n == LAT + 2) begin
        MemWrite = 1'b0; MemRead = 1'b0;
      end
      if (Ready) pulses++;
    end
    model_apply(1'b1, 32'h50, 32'h600D_F00D, 2'd2, 1'b0);
    chk("held_req_ready_pulses", 32'(pulses), 32'd1);
    do_access(1'b1, 1'b0, 32'h54, 32'h0, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b0, 32'h54, 32'h0, 2'd2, 1'b0);
    chk("ignored_write_0x54", rd, 32'h0101_0101);
    do_access(1'b1, 1'b0, 32'h50, 32'h0, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b0, 32'h50, 32'h0, 2'd2, 1'b0);
    chk("accepted_write_0x50", rd, 32'h600D_F00D);

    // Reset during WAIT aborts a pending write
    @(negedge Clk);
    MemWrite = 1'b1; Address = 32'h40; WriteData = 32'h0000_0055; Size = 2'd2;
    @(posedge Clk);
    @(negedge Clk);
    MemWrite = 1'b0; Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_rd = '0;
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      if (Ready) pulses++;
      @(negedge Clk);
    end
    chk("abort_ready_pulses", 32'(pulses), 32'd0);
    chk("abort_busy", {31'b0, Busy}, 32'h0);
    chk("abort_readdata", ReadData, 32'h0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    chk("abort_mem_0x40", rd, 32'h1234_5678);

    // MemRead and MemWrite together act as a write
    do_access(1'b1, 1'b1, 32'h44, 32'h7777_7777, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b1, 32'h44, 32'h7777_7777, 2'd2, 1'b0);
    chk("both_req_readdata_held", rd, 32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
    chk("both_req_written", rd, 32'h7777_7777);

    // Misaligned word write
    do_access(1'b0, 1'b1, 32'h42, 32'hCAFE_F00D, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b1, 32'h42, 32'hCAFE_F00D, 2'd2, 1'b0);
    chk("misalign_latency", 32'(lat), 32'(LAT + 1));
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_flag", {31'b0, mis}, 32'h1);
`else
    chk("misalign_flag", {31'b0, mis}, 32'h0);
`endif
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, lat, mis, bok);
    model_apply(1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misalign_mem_0x40", rd, 32'h1234_5678);
`else
    chk("misalign_mem_0x40", rd, 32'hCAFE_F00D);
`endif
    chk("misalign_flag_cleared", {31'b0, mis}, 32'h0);

    // Randomized traffic in a pre-initialized window
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      do_access(1'b0, 1'b1, 32'h100 + 32'(4*w), d, 2'd2, 1'b0, rd, lat, mis, bok);
      model_apply(1'b1, 32'h100 + 32'(4*w), d, 2'd2, 1'b0);
    end
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a, d;
      logic [1:0]  sz, op;
      logic        un;
      a  = 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a + 32'h0000_1000 * 32'($urandom_range(1, 7));
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(1, 3));
      do_access(op[0], op[1], a, d, sz, un, rd, lat, mis, bok);
      model_apply(op[1], a, d, sz, un);
      chk($sformatf("rand%0d_readdata a=%h sz=%0d op=%0d", k, a, sz, op), rd, model_rd);
      chk($sformatf("rand%0d_misalign", k), {31'b0, mis}, {31'b0, model_mis});
      chk($sformatf("rand%0d_latency", k), 32'(lat), 32'(LAT + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised, multi-cycle successor to the processor's single-cycle data memory.
- Adds byte, halfword and word access with sign/zero extension for the lb/lbu/lh/lhu/sb/sh/sw family.
- Adds configurable access latency with a Busy/Ready handshake toward the MEM-stage stall logic, and a parametrised depth.
- Sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- ADDR_BITS, 10, log2(DEPTH); word index is Address[ADDR_BITS+1:2].
- LATENCY, 2, cycles from request acceptance to access completion; must be >=1.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Address  in  32  byte address; bits above ADDR_BITS+1 are ignored, so addresses wrap modulo DEPTH*4.
- WriteData  in  32  store data; the low byte or halfword is used for sub-word stores.
- MemWrite  in  1  write request.
- MemRead  in  1  read request.
- Size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 is treated as word.
- Unsigned  in  1  for reads, 1 means zero-extend and 0 means sign-extend; ignored for word accesses.
- ReadData  out  32  extended load result; holds its value until the next read completes.
- Busy  out  1  high while a request is in flight.
- Ready  out  1  one-cycle completion pulse.
- MisalignErr  out  1  misaligned-access flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - state goes to IDLE; ReadData=0, Busy=0, Ready=0, MisalignErr=0; latency counter=0.
  - Memory array contents are not cleared.
  - Reset during WAIT aborts the access. A pending write is never committed.
- State IDLE:
  - A request (MemRead|MemWrite) sampled at edge E0 latches Address, WriteData, Size, Unsigned and the operation.
  - The counter is loaded with LATENCY-1 and the block goes to WAIT. Busy=1 from E0 onward.
  - If MemRead and MemWrite are both 1, the access is a write and the read is ignored.
- State WAIT:
  - The counter decrements each edge.
  - At the edge where the counter equals 0 (edge E_LATENCY), the access is performed and the block goes to DONE.
  - Inputs are ignored throughout WAIT.
- State DONE:
  - Lasts one cycle: Ready=1, Busy=0. ReadData is valid during this cycle for reads.
  - Requests present in DONE are ignored. The next edge returns the block to IDLE.
  - Minimum spacing between accepted requests is LATENCY+2 cycles.
- Lane and extension rules (little-endian):
  - Byte lane = Address[1:0]. Halfword lane = Address[1] (bytes 0-1 or 2-3).
  - Sub-word writes modify only the addressed bytes; the other bytes keep their old values (read-modify-write inside the block is acceptable).
  - Reads extract the addressed lane and extend it to 32 bits: sign-extend from bit 7/15 when Unsigned=0, zero-extend otherwise.
- Write completion does not change ReadData.
- No internal forwarding is needed: accesses are serialised.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with Address[0]=1, or a word access with Address[1:0]!=00, is misaligned.
  - A misaligned access performs no memory update and leaves ReadData unchanged.
  - The DONE cycle asserts Ready=1 and MisalignErr=1 together for one cycle. MisalignErr=0 otherwise.
- Undefined:
  - MisalignErr is constantly 0.
  - Alignment is forced: halfword ignores Address[0], word ignores Address[1:0]. Timing is otherwise identical.

Test Plan:
1. Reset high over two edges, then low -> ReadData=0, Busy=0, Ready=0. Word write 0xDEADBEEF to 0x10, then word read of 0x10 -> Ready pulses exactly LATENCY+1 edges after acceptance (cycle 3 for LATENCY=2); ReadData=0xDEADBEEF.
2. Store word 0x11223344 at 0x20. Store byte 0xAA to 0x21. Read word 0x20 -> 0x1122AA44. Then:
   - lb 0x21 -> 0xFFFFFFAA.
   - lbu 0x21 -> 0x000000AA.
   - lh 0x22 -> 0x00001122.
3. Store halfword 0x8001 to 0x32, then:
   - lh 0x32 -> 0xFFFF8001.
   - lhu 0x32 -> 0x00008001.
   - Word read of 0x30 -> 0x8001xxxx (low half unchanged).
4. Second request asserted during WAIT and during DONE -> ignored: only one Ready pulse, memory unchanged by the ignored request. Also, with DEPTH=1024, a write to 0x1000 followed by a read of 0x0000 returns the same word (address wrap).
5. Start a write of 0x55 to 0x40, assert Reset during WAIT -> no Ready pulse; a later read of 0x40 returns the prior contents. MemRead and MemWrite both high -> treated as a write; ReadData keeps its previous value.
6. With DMEM_MISALIGN_TRAP_EN, word write to 0x42 -> MisalignErr=1 with Ready, memory unchanged. Without the macro, the same write updates word 0x40 and MisalignErr stays 0.
